instruction_decode: RTL and testbench

Decode stage of the 64-bit LEGv8 pipeline, directly upstream of the execution stage. Reads the 32×64 register file, generates control signals and sign-extended immediates from the fetched instruction, and presents them through a registered ID/EX boundary. Also hosts the register file write port driven by writeback. Supports stall (hold) and flush (bubble) from the hazard logic.

---
 rtl/legv8_pkg.sv | 61 ++++++
 rtl/register_file.sv | 42 ++++
 rtl/instruction_decode.sv | 181 ++++++++++++++++++
 tb/tb_instruction_decode.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: datapath width, opcode patterns, ALU control
// encodings, the control bundle carried through ID/EX, and the immediate
// format selector used by the decoder.
package legv8_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam logic [4:0] XZR = 5'd31;

  // Full 11-bit opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // I-type opcodes are 10 bits (opcode[10:1])
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;

  // CB-type opcodes are 8 bits, B-type 6 bits
  localparam logic [7:0] OP_CBZ  = 8'b10110100;
  localparam logic [7:0] OP_CBNZ = 8'b10110101;
  localparam logic [5:0] OP_B    = 6'b000101;

  typedef enum logic [1:0] {
    ALUSRC_REG  = 2'b00,
    ALUSRC_DIMM = 2'b01,
    ALUSRC_IIMM = 2'b10
  } alusrc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } aluop_e;

  typedef struct packed {
    alusrc_e alu_src;
    aluop_e  alu_op;
    logic    b;
    logic    bz;
    logic    bnz;
    logic    mem_write;
    logic    mem_read;
    logic    mem_to_reg;
    logic    reg_write;
  } ctrl_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_D,
    IMM_I,
    IMM_CB,
    IMM_B
  } imm_kind_e;

endpackage

// File: rtl/register_file.sv
// 32 x XLEN register file with two combinational read ports and one write
// port. X31 reads as zero and ignores writes. A read of the register being
// written in the same cycle returns the incoming write data.
// Ports:
//   clk, reset           clock, synchronous active-high reset (clears all)
//   raddr[2], rdata[2]   read ports
//   we, waddr, wdata     write port, commits on the rising edge
module register_file
  import legv8_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0][4:0]           raddr,
  output logic [1:0][XLEN-1:0]      rdata,
  input  logic                      we,
  input  logic [4:0]                waddr,
  input  logic [XLEN-1:0]           wdata
);

  logic [XLEN-1:0] regs_reg [NREGS];

  // Entry 31 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (we && waddr != XZR) begin
      regs_reg[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    always_comb begin
      if (raddr[gi] == XZR)
        rdata[gi] = '0;
      else if (we && waddr == raddr[gi])
        rdata[gi] = wdata;
      else
        rdata[gi] = regs_reg[raddr[gi]];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 decode stage: reads operands, decodes control, extends immediates
// and registers everything into the ID/EX boundary. Hosts the writeback
// port of the register file.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   if_valid, if_instr, if_pc          fetched instruction
//   stall, flush                       hold / bubble ID/EX (flush wins)
//   wb_reg_write, wb_reg, wb_data      register file write port
//   ex_valid .. illegal                registered ID/EX outputs
module instruction_decode
  import legv8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [63:0]       if_pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_reg,
  input  logic [63:0]       wb_data,
  output logic              ex_valid,
  output logic [31:0]       Instruction,
  output logic [63:0]       Address,
  output logic [63:0]       signExtInstr,
  output logic [63:0]       Data1,
  output logic [63:0]       Data2,
  output logic [4:0]        Reg2Write,
  output logic [1:0]        ALUSrc,
  output logic [1:0]        ALUOp,
  output logic              B,
  output logic              BZ,
  output logic              BNZ,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              illegal
);

  logic [10:0]          opcode;
  ctrl_t                ctrl_next;
  imm_kind_e            imm_kind;
  logic                 illegal_next;
  logic                 reg2loc;
  logic [XLEN-1:0]      imm_next;
  logic [1:0][4:0]      raddr;
  logic [1:0][XLEN-1:0] rdata;

  assign opcode = if_instr[31:21];

  always_comb begin
    ctrl_next    = '0;
    imm_kind     = IMM_NONE;
    illegal_next = 1'b0;
    reg2loc      = 1'b0;
    if (opcode == OP_ADD || opcode == OP_SUB ||
        opcode == OP_AND || opcode == OP_ORR) begin
      ctrl_next.alu_src   = ALUSRC_REG;
      ctrl_next.alu_op    = ALUOP_FUNCT;
      ctrl_next.reg_write = 1'b1;
    end else if (opcode[10:1] == OP_ADDI || opcode[10:1] == OP_SUBI ||
                 opcode[10:1] == OP_ANDI || opcode[10:1] == OP_ORRI) begin
      ctrl_next.alu_src   = ALUSRC_IIMM;
      ctrl_next.alu_op    = ALUOP_FUNCT;
      ctrl_next.reg_write = 1'b1;
      imm_kind            = IMM_I;
    end else if (opcode == OP_LDUR) begin
      ctrl_next.alu_src    = ALUSRC_DIMM;
      ctrl_next.alu_op     = ALUOP_ADD;
      ctrl_next.mem_read   = 1'b1;
      ctrl_next.mem_to_reg = 1'b1;
      ctrl_next.reg_write  = 1'b1;
      imm_kind             = IMM_D;
    end else if (opcode == OP_STUR) begin
      ctrl_next.alu_src   = ALUSRC_DIMM;
      ctrl_next.alu_op    = ALUOP_ADD;
      ctrl_next.mem_write = 1'b1;
      imm_kind            = IMM_D;
      reg2loc             = 1'b1;
    end else if (opcode[10:3] == OP_CBZ) begin
      ctrl_next.alu_op = ALUOP_BRANCH;
      ctrl_next.bz     = 1'b1;
      imm_kind         = IMM_CB;
      reg2loc          = 1'b1;
    end else if (opcode[10:3] == OP_CBNZ) begin
      ctrl_next.alu_op = ALUOP_BRANCH;
      ctrl_next.bnz    = 1'b1;
      imm_kind         = IMM_CB;
      reg2loc          = 1'b1;
    end else if (opcode[10:5] == OP_B) begin
      ctrl_next.alu_op = ALUOP_BRANCH;
      ctrl_next.b      = 1'b1;
      imm_kind         = IMM_B;
    end else begin
      illegal_next = 1'b1;
    end
  end

  always_comb begin
    imm_next = '0;
    case (imm_kind)
      IMM_D:   imm_next = {{(XLEN-9){if_instr[20]}},  if_instr[20:12]};
      IMM_CB:  imm_next = {{(XLEN-19){if_instr[23]}}, if_instr[23:5]};
      IMM_B:   imm_next = {{(XLEN-26){if_instr[25]}}, if_instr[25:0]};
      IMM_I:   imm_next = {{(XLEN-12){1'b0}},         if_instr[21:10]};
      default: imm_next = '0;
    endcase
  end

  // Stores and compare-branches read their data/test register from Rt.
  assign raddr[0] = if_instr[9:5];
  assign raddr[1] = reg2loc ? if_instr[4:0] : if_instr[20:16];

  register_file u_register_file (
    .clk   (clk),
    .reset (reset),
    .raddr (raddr),
    .rdata (rdata),
    .we    (wb_reg_write),
    .waddr (wb_reg),
    .wdata (wb_data)
  );

  logic            valid_reg;
  ctrl_t           ctrl_reg;
  logic            illegal_reg;
  logic [31:0]     instr_reg;
  logic [63:0]     pc_reg;
  logic [63:0]     imm_reg;
  logic [63:0]     data1_reg;
  logic [63:0]     data2_reg;
  logic [4:0]      rd_reg;

  // Reset, flush and an invalid fetch (when not stalled) all load a zero
  // bubble. Stall holds the stage, so a writeback during stall does not
  // refresh the held operands.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !if_valid)) begin
      valid_reg   <= 1'b0;
      ctrl_reg    <= '0;
      illegal_reg <= 1'b0;
      instr_reg   <= '0;
      pc_reg      <= '0;
      imm_reg     <= '0;
      data1_reg   <= '0;
      data2_reg   <= '0;
      rd_reg      <= '0;
    end else if (!stall) begin
      valid_reg   <= 1'b1;
      ctrl_reg    <= ctrl_next;
      illegal_reg <= illegal_next;
      instr_reg   <= if_instr;
      pc_reg      <= if_pc;
      imm_reg     <= imm_next;
      data1_reg   <= rdata[0];
      data2_reg   <= rdata[1];
      rd_reg      <= if_instr[4:0];
    end
  end

  assign ex_valid     = valid_reg;
  assign Instruction  = instr_reg;
  assign Address      = pc_reg;
  assign signExtInstr = imm_reg;
  assign Data1        = data1_reg;
  assign Data2        = data2_reg;
  assign Reg2Write    = rd_reg;
  assign ALUSrc       = ctrl_reg.alu_src;
  assign ALUOp        = ctrl_reg.alu_op;
  assign B            = ctrl_reg.b;
  assign BZ           = ctrl_reg.bz;
  assign BNZ          = ctrl_reg.bnz;
  assign MemWrite     = ctrl_reg.mem_write;
  assign MemRead      = ctrl_reg.mem_read;
  assign MemtoReg     = ctrl_reg.mem_to_reg;
  assign RegWrite     = ctrl_reg.reg_write;
  assign illegal      = illegal_reg;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-encoded LEGv8 instructions
// with hand-computed expected ID/EX contents.
module tb_instruction_decode;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        stall;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        ex_valid;
  logic [31:0] Instruction;
  logic [63:0] Address;
  logic [63:0] signExtInstr;
  logic [63:0] Data1;
  logic [63:0] Data2;
  logic [4:0]  Reg2Write;
  logic [1:0]  ALUSrc;
  logic [1:0]  ALUOp;
  logic        B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  instruction_decode dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .stall        (stall),
    .flush        (flush),
    .wb_reg_write (wb_reg_write),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .ex_valid     (ex_valid),
    .Instruction  (Instruction),
    .Address      (Address),
    .signExtInstr (signExtInstr),
    .Data1        (Data1),
    .Data2        (Data2),
    .Reg2Write    (Reg2Write),
    .ALUSrc       (ALUSrc),
    .ALUOp        (ALUOp),
    .B            (B),
    .BZ           (BZ),
    .BNZ          (BNZ),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flags = {B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite}
  task automatic check_ctrl(input string tag, input logic [1:0] src,
                            input logic [1:0] op, input logic [6:0] flags);
    check({tag, ".ALUSrc"}, 64'(ALUSrc), 64'(src));
    check({tag, ".ALUOp"},  64'(ALUOp),  64'(op));
    check({tag, ".flags"},
          64'({B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite}), 64'(flags));
  endtask

  task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    tick();
  endtask

  task automatic set_wb(input logic en, input logic [4:0] r, input logic [63:0] d);
    wb_reg_write = en;
    wb_reg       = r;
    wb_data      = d;
  endtask

  localparam logic [31:0] I_ADD      = 32'h8B020023; // ADD X3,X1,X2
  localparam logic [31:0] I_ADD_ZR   = 32'h8B1F03E3; // ADD X3,XZR,XZR
  localparam logic [31:0] I_LDUR     = 32'hF85F8024; // LDUR X4,[X1,#-8]
  localparam logic [31:0] I_STUR     = 32'hF8010022; // STUR X2,[X1,#16]
  localparam logic [31:0] I_CBZ      = 32'hB4FFFFE5; // CBZ X5,#-1
  localparam logic [31:0] I_CBNZ     = 32'hB5000045; // CBNZ X5,#2
  localparam logic [31:0] I_B        = 32'h17FFFFFF; // B #-1
  localparam logic [31:0] I_ADDI     = 32'h913FFC26; // ADDI X6,X1,#0xFFF
  localparam logic [31:0] I_ILL      = 32'hFFE00000; // opcode 0x7FF
  localparam logic [31:0] I_ILL2     = 32'hF8600000; // opcode 11111000011

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    stall = 1'b0; flush = 1'b0;
    set_wb(1'b0, 5'd0, 64'd0);

    // Reset state
    tick(); tick();
    check("reset.ex_valid", 64'(ex_valid), 64'd0);
    check("reset.Instruction", 64'(Instruction), 64'd0);
    check_ctrl("reset", 2'b00, 2'b00, 7'b0000000);

    // Populate X1=5, X2=7
    reset = 1'b0;
    set_wb(1'b1, 5'd1, 64'd5); tick();
    set_wb(1'b1, 5'd2, 64'd7); tick();
    set_wb(1'b0, 5'd0, 64'd0);

    // ADD X3,X1,X2
    issue(I_ADD, 64'h100);
    check("add.Data1", Data1, 64'd5);
    check("add.Data2", Data2, 64'd7);
    check("add.Reg2Write", 64'(Reg2Write), 64'd3);
    check("add.ex_valid", 64'(ex_valid), 64'd1);
    check("add.Address", Address, 64'h100);
    check("add.Instruction", 64'(Instruction), 64'(I_ADD));
    check("add.imm", signExtInstr, 64'd0);
    check("add.illegal", 64'(illegal), 64'd0);
    check_ctrl("add", 2'b00, 2'b10, 7'b0000001);

    // LDUR, while X5=0x1234 is written back
    set_wb(1'b1, 5'd5, 64'h1234);
    issue(I_LDUR, 64'h104);
    set_wb(1'b0, 5'd0, 64'd0);
    check("ldur.imm", signExtInstr, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur.Data1", Data1, 64'd5);
    check("ldur.Reg2Write", 64'(Reg2Write), 64'd4);
    check_ctrl("ldur", 2'b01, 2'b00, 7'b0000111);

    // CBZ X5, imm19=-1
    issue(I_CBZ, 64'h108);
    check("cbz.imm", signExtInstr, 64'hFFFF_FFFF_FFFF_FFFF);
    check("cbz.Data2", Data2, 64'h1234);
    check_ctrl("cbz", 2'b00, 2'b01, 7'b0100000);

    // CBNZ X5, imm19=2
    issue(I_CBNZ, 64'h10C);
    check("cbnz.imm", signExtInstr, 64'd2);
    check("cbnz.Data2", Data2, 64'h1234);
    check_ctrl("cbnz", 2'b00, 2'b01, 7'b0010000);

    // B imm26=0x3FFFFFF
    issue(I_B, 64'h110);
    check("b.imm", signExtInstr, 64'hFFFF_FFFF_FFFF_FFFF);
    check_ctrl("b", 2'b00, 2'b01, 7'b1000000);

    // STUR X2,[X1,#16]
    issue(I_STUR, 64'h114);
    check("stur.imm", signExtInstr, 64'd16);
    check("stur.Data1", Data1, 64'd5);
    check("stur.Data2", Data2, 64'd7);
    check_ctrl("stur", 2'b01, 2'b00, 7'b0001000);

    // ADDI X6,X1,#0xFFF (zero-extended)
    issue(I_ADDI, 64'h118);
    check("addi.imm", signExtInstr, 64'h0000_0000_0000_0FFF);
    check("addi.Data1", Data1, 64'd5);
    check_ctrl("addi", 2'b10, 2'b10, 7'b0000001);

    // Same-cycle write-through bypass on X1
    set_wb(1'b1, 5'd1, 64'hAA);
    issue(I_ADD, 64'h11C);
    check("bypass.Data1", Data1, 64'hAA);
    check("bypass.Data2", Data2, 64'd7);

    // Write to X31 is dropped and never bypassed
    set_wb(1'b1, 5'd31, 64'h55);
    issue(I_ADD_ZR, 64'h120);
    check("xzr_same.Data1", Data1, 64'd0);
    check("xzr_same.Data2", Data2, 64'd0);
    set_wb(1'b0, 5'd0, 64'd0);
    issue(I_ADD_ZR, 64'h124);
    check("xzr_later.Data1", Data1, 64'd0);
    check("xzr_later.Data2", Data2, 64'd0);

    // Stall for 3 cycles while X1 is rewritten: outputs hold
    issue(I_ADD, 64'h200);
    check("prestall.Data1", Data1, 64'hAA);
    stall = 1'b1;
    if_instr = I_LDUR; if_pc = 64'h204;
    set_wb(1'b1, 5'd1, 64'h99);
    tick(); tick(); tick();
    check("stall.Data1", Data1, 64'hAA);
    check("stall.Address", Address, 64'h200);
    check("stall.Instruction", 64'(Instruction), 64'(I_ADD));
    check_ctrl("stall", 2'b00, 2'b10, 7'b0000001);
    stall = 1'b0;
    set_wb(1'b0, 5'd0, 64'd0);
    issue(I_ADD, 64'h208);
    check("poststall.Data1", Data1, 64'h99);
    check("poststall.Address", Address, 64'h208);

    // Stall and flush together: bubble
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    check("flush.ex_valid", 64'(ex_valid), 64'd0);
    check("flush.Data1", Data1, 64'd0);
    check_ctrl("flush", 2'b00, 2'b00, 7'b0000000);

    // if_valid=0 loads a bubble
    if_valid = 1'b0; if_instr = I_ADD; if_pc = 64'h20C;
    tick();
    check("invalid.ex_valid", 64'(ex_valid), 64'd0);
    check("invalid.RegWrite", 64'(RegWrite), 64'd0);

    // Unknown opcodes
    issue(I_ILL, 64'h300);
    check("ill.illegal", 64'(illegal), 64'd1);
    check("ill.imm", signExtInstr, 64'd0);
    check_ctrl("ill", 2'b00, 2'b00, 7'b0000000);
    issue(I_ILL2, 64'h304);
    check("ill2.illegal", 64'(illegal), 64'd1);
    check_ctrl("ill2", 2'b00, 2'b00, 7'b0000000);

    // Reset mid-stream
    issue(I_ADD, 64'h308);
    check("prereset.Data1", Data1, 64'h99);
    reset = 1'b1;
    tick();
    check("midreset.ex_valid", 64'(ex_valid), 64'd0);
    check("midreset.Data1", Data1, 64'd0);
    check("midreset.Address", Address, 64'd0);
    check("midreset.Instruction", 64'(Instruction), 64'd0);
    check_ctrl("midreset", 2'b00, 2'b00, 7'b0000000);
    reset = 1'b0;
    issue(I_ADD, 64'h400);
    check("afterreset.Data1", Data1, 64'd0);
    check("afterreset.Data2", Data2, 64'd0);
    check("afterreset.ex_valid", 64'(ex_valid), 64'd1);
    issue(I_CBZ, 64'h404);
    check("afterreset.X5", Data2, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
